// File: rtl/serial_subtraction_design_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_subtraction_design_if: start/busy/done bus of the serial subtractor
// Rev 1.0
// ----------------------------------------------------------------------------
interface serial_subtraction_design_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   dout;

  modport master (
    output start, num1, num2,
    input  busy, done, dout
  );

  modport slave (
    input  start, num1, num2,
    output busy, done, dout
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtraction_design.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_subtraction_design: bit-serial unsigned num1 - num2, LSB first
// Rev 1.0
// ----------------------------------------------------------------------------
module serial_subtraction_design #(
  parameter int WIDTH = 8
) (
  input wire clk,
  input wire reset,
  serial_subtraction_design_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   dout_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             diff;
  logic             borrow_next;
  logic             last_bit;

  always_comb begin
    diff        = a[0] ^ b[0] ^ borrow;
    borrow_next = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & borrow);
    last_bit    = (cnt == LAST);
    state_next  = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      res      <= '0;
      borrow   <= 1'b0;
      cnt      <= '0;
      dout_reg <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      state    <= state_next;
      // Flags follow the next state so they are true flops, not state decodes.
      busy_reg <= (state_next != IDLE);
      done_reg <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            a      <= bus.num1;
            b      <= bus.num2;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          res    <= {diff, res[WIDTH-1:1]};
          a      <= a >> 1;
          b      <= b >> 1;
          borrow <= borrow_next;
          cnt    <= cnt + 1'b1;
          // dout is only ever written with a complete result.
          if (last_bit) dout_reg <= {borrow_next, diff, res[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.dout = dout_reg;

endmodule
`default_nettype wire
